// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier and divider).
// Both units use the same one-hot controller encoding, so one controller can drive either.
package arith_pkg;

  // One-hot controller states, common to the multiplier and the divider.
  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] LOAD = 4'b0010;
  localparam logic [3:0] EXEC = 4'b0100;
  localparam logic [3:0] DONE = 4'b1000;

  typedef logic [3:0] state_t;

  // Width of an iteration counter that must hold values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration.
// The remainder is shifted left and receives the dividend MSB. The divisor is
// subtracted when it fits, and the quotient bit is shifted in from the right.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] r_o,
  output logic [N-1:0] q_o
);

  logic [N:0] t;

  // Compare and subtract on N+1 bits: the shifted remainder can reach 2*D-1.
  always_comb begin
    t = {r_i, q_i[N-1]};
    if (t >= {1'b0, d_i}) begin
      r_o = N'(t - {1'b0, d_i});
      q_o = {q_i[N-2:0], 1'b1};
    end else begin
      r_o = t[N-1:0];
      q_o = {q_i[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider. It produces one quotient bit per clock.
//
// Handshake: start is sampled only in IDLE. ready is a level. It drops on the
// edge that accepts start, and it rises on the edge that publishes the results.
// It then stays high until the next start is accepted. A start held high is
// not queued. It is seen again only once the FSM is back in IDLE.
//
// R is held as N bits. After each step the remainder is smaller than D, so its
// (N+1)-th bit is always zero between iterations. The (N+1)-bit width is needed
// only inside the step, for the compare and the subtract.
module seq_divider
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic [3:0]   state_dbg
);

  localparam int CW = cnt_width(N);

  state_t         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           ready_q, ready_d;
  logic           dbz_q, dbz_d;
  logic [N-1:0]   step_r, step_q;

  div_step #(.N(N)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A zero divisor skips EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = (divisor == '0) ? DONE : EXEC;
      EXEC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      dbz_q       <= dbz_d;
    end
  end

  // Datapath next values for each controller state.
  always_comb begin
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = ready_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ready_d = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      LOAD: begin
        q_d   = dividend;
        d_d   = divisor;
        r_d   = '0;
        cnt_d = CW'(N - 1);
        dz_d  = (divisor == '0);
      end
      EXEC: begin
        q_d = step_q;
        r_d = step_r;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      DONE: begin
        ready_d = 1'b1;
        if (dz_q) begin
          // EXEC never ran, so Q still holds the dividend captured in LOAD.
          quotient_d  = '1;
          remainder_d = q_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = q_q;
          remainder_d = r_q;
        end
      end
      default: ;
    endcase
  end

  assign ready       = ready_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule
